// File: rtl/pattern_sequencer.sv
// Drives a sequence detector from a stored pattern: clears it, shifts the pattern in
// MSB-first with a gated enable, and counts the detector's z pulses for the run.
module pattern_sequencer #(
    parameter int MAX_LEN = 32,
    parameter int CNT_W   = 7,
    parameter int Z_LAT   = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [MAX_LEN-1:0]             pat,
    input  logic [$clog2(MAX_LEN+1)-1:0]   len,
    input  logic                           hold,
    input  logic                           det_z,
    output logic                           det_sig,
    output logic                           det_ena,
    output logic                           det_rst,
    output logic                           busy,
    output logic                           done,
    output logic [CNT_W-1:0]               hits,
    output logic [2:0]                     dbg_state
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] HITS_MAX = {CNT_W{1'b1}};
    localparam logic [1:0] DRAIN_LOAD = (Z_LAT > 0) ? 2'(Z_LAT - 1) : 2'd0;

    // Encoding is visible on dbg_state: 0 idle, 1 clear, 2 shift, 3 drain, 4 done.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state;
    logic [MAX_LEN-1:0] sr;
    logic [LEN_W-1:0]   bit_cnt;
    logic [LEN_W-1:0]   len_c;
    logic [LEN_W-1:0]   shamt;
    logic [1:0]         drain_cnt;
    logic               z_en;

    always_comb begin
        len_c = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
        shamt = LEN_W'(MAX_LEN) - len_c;
    end

    assign det_ena   = (state == S_SHIFT) && !hold;
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            det_rst   <= 1'b1;
            det_sig   <= 1'b0;
            done      <= 1'b0;
            sr        <= '0;
            bit_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    det_rst <= 1'b0;
                    if (start) begin
                        // Left-align so bit len-1 sits at the MSB.
                        sr      <= pat << shamt;
                        bit_cnt <= len_c;
                        if (len_c == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= S_CLEAR;
                            det_rst <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    det_rst <= 1'b0;
                    det_sig <= sr[MAX_LEN-1];
                    state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (!hold) begin
                        sr      <= sr << 1;
                        bit_cnt <= bit_cnt - 1'b1;
                        if (bit_cnt == LEN_W'(1)) begin
                            det_sig <= 1'b0;
                            if (Z_LAT > 0) begin
                                state     <= S_DRAIN;
                                drain_cnt <= DRAIN_LOAD;
                            end else begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            det_sig <= sr[MAX_LEN-2];
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == 2'd0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // z is only meaningful Z_LAT cycles after a bit was actually presented.
    generate
        if (Z_LAT == 0) begin : g_no_lat
            assign z_en = det_ena;
        end else begin : g_lat
            logic [Z_LAT-1:0] ena_dl;
            always_ff @(posedge clk) begin
                if (!rst) ena_dl <= '0;
                else      ena_dl <= Z_LAT'({ena_dl, det_ena});
            end
            assign z_en = ena_dl[Z_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst)
            hits <= '0;
        else if (state == S_CLEAR || (state == S_IDLE && start && len_c == '0))
            hits <= '0;
        else if (z_en && det_z && hits != HITS_MAX)
            hits <= hits + 1'b1;
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: two instances (Z_LAT=0/CNT_W=7 and Z_LAT=2/CNT_W=2)
// share stimulus; a timeline model derived from the run parameters predicts every cycle.
module tb_pattern_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, hold;
    logic [31:0] pat;
    logic [5:0]  len;
    logic        det_z     [2];
    logic        det_sig   [2];
    logic        det_ena   [2];
    logic        det_rst   [2];
    logic        busy      [2];
    logic        done      [2];
    logic [2:0]  dbg_state [2];
    logic [6:0]  hits0;
    logic [1:0]  hits2;
    logic [6:0]  hits_w    [2];

    int total  = 0;
    int passes = 0;

    assign hits_w[0] = hits0;
    assign hits_w[1] = {5'b0, hits2};

    pattern_sequencer #(.MAX_LEN(32), .CNT_W(7), .Z_LAT(0)) u_lat0 (
        .clk(clk), .rst(rst), .start(start), .pat(pat), .len(len), .hold(hold),
        .det_z(det_z[0]), .det_sig(det_sig[0]), .det_ena(det_ena[0]), .det_rst(det_rst[0]),
        .busy(busy[0]), .done(done[0]), .hits(hits0), .dbg_state(dbg_state[0])
    );

    pattern_sequencer #(.MAX_LEN(32), .CNT_W(2), .Z_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .start(start), .pat(pat), .len(len), .hold(hold),
        .det_z(det_z[1]), .det_sig(det_sig[1]), .det_ena(det_ena[1]), .det_rst(det_rst[1]),
        .busy(busy[1]), .done(done[1]), .hits(hits2), .dbg_state(dbg_state[1])
    );

    task automatic chk(input string tag, input int u, input int cyc,
                       input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s u%0d cyc %0d: observed %0h expected %0h", tag, u, cyc, obs, exp);
    endtask

    // One run: start in cycle 0, optional ignored start at restart_c, optional reset at rst_c.
    task automatic run_case(input logic [31:0] p, input logic [5:0] l, input logic [127:0] hv,
                            input logic [127:0] zv0, input logic [127:0] zv2,
                            input int restart_c, input int rst_c);
        int lat  [2] = '{0, 2};
        int hmax [2] = '{127, 3};
        bit ena_e [128];
        bit sig_e [128];
        int dn [2];
        int he [2];
        int st_e;
        logic [127:0] zv [2];
        int lc, c, k, last, end_c;

        zv[0] = zv0;
        zv[1] = zv2;
        foreach (ena_e[i]) begin
            ena_e[i] = 1'b0;
            sig_e[i] = 1'b0;
        end
        lc = (l > 6'd32) ? 32 : int'(l);
        c = 2;
        k = 0;
        while (k < lc && c < 120) begin
            sig_e[c] = p[lc-1-k];
            if (!hv[c]) begin
                ena_e[c] = 1'b1;
                k++;
            end
            c++;
        end
        last = c - 1;
        for (int u = 0; u < 2; u++) begin
            dn[u] = (lc == 0) ? 1 : last + 1 + lat[u];
            he[u] = 0;
            for (int e = 0; e < 120; e++)
                if (ena_e[e] && zv[u][e+lat[u]]) he[u]++;
            if (he[u] > hmax[u]) he[u] = hmax[u];
        end
        end_c = (rst_c >= 0) ? rst_c + 2 : ((dn[0] > dn[1]) ? dn[0] : dn[1]) + 1;

        for (int cyc = 0; cyc <= end_c; cyc++) begin
            rst   = (cyc == rst_c) ? 1'b0 : 1'b1;
            start = (cyc == 0 || cyc == restart_c);
            if (cyc == 0) begin
                pat = p;
                len = l;
            end else begin
                pat = $urandom;
                len = 6'($urandom_range(0, 63));
            end
            hold     = hv[cyc];
            det_z[0] = zv0[cyc];
            det_z[1] = zv2[cyc];
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                if (rst_c >= 0 && cyc > rst_c) begin
                    chk("rst_busy", u, cyc, busy[u], 0);
                    chk("rst_ena", u, cyc, det_ena[u], 0);
                    chk("rst_det_rst", u, cyc, det_rst[u], (cyc == rst_c + 1) ? 1 : 0);
                    chk("rst_state", u, cyc, dbg_state[u], 0);
                    if (cyc == rst_c + 1) chk("rst_hits", u, cyc, hits_w[u], 0);
                end else begin
                    if (cyc == 0 || cyc > dn[u])      st_e = 0;
                    else if (cyc == dn[u])            st_e = 4;
                    else if (cyc == 1)                st_e = 1;
                    else if (cyc <= last)             st_e = 2;
                    else                              st_e = 3;
                    chk("busy", u, cyc, busy[u], (cyc >= 1 && cyc <= dn[u]) ? 1 : 0);
                    chk("done", u, cyc, done[u], (cyc == dn[u]) ? 1 : 0);
                    chk("det_ena", u, cyc, det_ena[u], ena_e[cyc]);
                    chk("det_sig", u, cyc, det_sig[u], sig_e[cyc]);
                    chk("det_rst", u, cyc, det_rst[u], (cyc == 1 && lc > 0) ? 1 : 0);
                    chk("state", u, cyc, dbg_state[u], st_e);
                    if (cyc >= dn[u]) chk("hits", u, cyc, hits_w[u], he[u]);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [127:0] hv, z0, z2;

        rst = 1'b0; start = 1'b0; hold = 1'b0; pat = '0; len = '0;
        det_z[0] = 1'b0; det_z[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("reset_busy", u, -1, busy[u], 0);
            chk("reset_done", u, -1, done[u], 0);
            chk("reset_ena", u, -1, det_ena[u], 0);
            chk("reset_sig", u, -1, det_sig[u], 0);
            chk("reset_hits", u, -1, hits_w[u], 0);
            chk("reset_det_rst", u, -1, det_rst[u], 1);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        for (int u = 0; u < 2; u++) chk("idle_det_rst", u, -1, det_rst[u], 0);
        @(posedge clk);
        #1;

        // Nominal: z pulses on bits 7, 16, 23 for the zero-latency instance.
        z0 = '0; z0[9] = 1'b1; z0[18] = 1'b1; z0[25] = 1'b1;
        z2 = {$urandom, $urandom, $urandom, $urandom};
        run_case(32'h0013_1753, 6'd24, '0, z0, z2, -1, -1);

        // Latency: z two cycles after each '1' bit, plus a stray pulse in the clear cycle.
        z2 = '0; z2[1] = 1'b1; z2[4] = 1'b1; z2[6] = 1'b1;
        run_case(32'h0000_000A, 6'd4, '0, z2, z2, -1, -1);

        // Hold for cycles 5-7.
        hv = '0; hv[5] = 1'b1; hv[6] = 1'b1; hv[7] = 1'b1;
        run_case($urandom, 6'd8, hv, {$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, -1, -1);

        // Saturation with det_z stuck high.
        run_case($urandom, 6'd8, '0, '1, '1, -1, -1);

        // Length edge cases.
        run_case($urandom, 6'd0, '0, '1, '1, -1, -1);
        run_case($urandom, 6'd40, '0, {$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, -1, -1);
        run_case($urandom, 6'd32, '0, '1, '1, -1, -1);
        run_case($urandom, 6'd1, '0, '1, '1, -1, -1);

        // Start during SHIFT is ignored; reset during bit 5 aborts the run.
        run_case($urandom, 6'd16, '0, '1, '1, 5, -1);
        run_case($urandom, 6'd16, '0, '1, '1, -1, 7);

        for (int r = 0; r < 16; r++) begin
            hv = '0;
            for (int i = 0; i < 100; i++) hv[i] = ($urandom_range(0, 3) == 0);
            run_case($urandom, 6'($urandom_range(0, 40)), hv,
                     {$urandom, $urandom, $urandom, $urandom},
                     {$urandom, $urandom, $urandom, $urandom}, -1, -1);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
